// File: rtl/data_mem_responder.sv
// Data-memory responder: round-robin arbitration of per-port read/write requests
// onto a single-port array, with a fixed access latency and a hold-until-valid-low response.
module data_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           read_valid,
    input  logic [ADDR_BITS*NUM_PORTS-1:0] read_address,
    output logic [NUM_PORTS-1:0]           read_ready,
    output logic [DATA_BITS*NUM_PORTS-1:0] read_data,
    input  logic [NUM_PORTS-1:0]           write_valid,
    input  logic [ADDR_BITS*NUM_PORTS-1:0] write_address,
    input  logic [DATA_BITS*NUM_PORTS-1:0] write_data,
    output logic [NUM_PORTS-1:0]           write_ready,
    output logic                           busy
);

    localparam int unsigned NumReq = 2 * NUM_PORTS;
    localparam int unsigned IdxW   = $clog2(NumReq);
    localparam int unsigned LatW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned Depth  = 1 << ADDR_BITS;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StRespond = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [LatW-1:0]      lat_q, lat_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [NUM_PORTS-1:0] rready_q, rready_d;
    logic [NUM_PORTS-1:0] wready_q, wready_d;
    logic [DATA_BITS-1:0] rdata_q [NUM_PORTS];
    logic [DATA_BITS-1:0] mem_q [Depth];

    logic [NumReq-1:0]    req;
    logic                 grant_valid;
    logic [IdxW-1:0]      grant_idx;
    logic [IdxW:0]        cand;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    logic                 grant_is_write;
    logic                 commit;
    logic                 mem_we;

    // Requester k < NUM_PORTS is read port k; NUM_PORTS + k is write port k.
    assign req            = {write_valid, read_valid};
    assign grant_is_write = (grant_q >= IdxW'(NUM_PORTS));

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (!grant_valid && req[cand[IdxW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == IdxW'(p)) begin
                sel_addr = read_address[p*ADDR_BITS +: ADDR_BITS];
            end
            if (grant_idx == IdxW'(p + NUM_PORTS)) begin
                sel_addr  = write_address[p*ADDR_BITS +: ADDR_BITS];
                sel_wdata = write_data[p*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rready_d = rready_q;
        wready_d = wready_q;
        commit   = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant_d  = grant_idx;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    rr_ptr_d = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
                    lat_d    = LatW'(LATENCY - 1);
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LatW'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = StRespond;
                    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                        rready_d[p] = (grant_q == IdxW'(p));
                        wready_d[p] = (grant_q == IdxW'(p + NUM_PORTS));
                    end
                end
            end
            StRespond: begin
                // Ready is held until valid is sampled low, so it drops one cycle later.
                if (!req[grant_q]) begin
                    state_d  = StIdle;
                    rready_d = '0;
                    wready_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            lat_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rready_q <= '0;
            wready_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rready_q <= rready_d;
            wready_q <= wready_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                rdata_q[p] <= '0;
            end else if (commit && !grant_is_write && (grant_q == IdxW'(p))) begin
                rdata_q[p] <= mem_q[addr_q];
            end
        end
    end

    // The array has no reset; a reset on the commit edge cancels the in-flight write.
    assign mem_we = commit && grant_is_write && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        read_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            read_data[p*DATA_BITS +: DATA_BITS] = rdata_q[p];
        end
    end

    assign read_ready  = rready_q;
    assign write_ready = wready_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with default parameters
// (8-bit address/data, 4 ports, LATENCY = 2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  read_valid;
    logic [31:0] read_address;
    logic [3:0]  read_ready;
    logic [31:0] read_data;
    logic [3:0]  write_valid;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [3:0]  write_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .read_valid   (read_valid),
        .read_address (read_address),
        .read_ready   (read_ready),
        .read_data    (read_data),
        .write_valid  (write_valid),
        .write_address(write_address),
        .write_data   (write_data),
        .write_ready  (write_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Returns the cycle index (0 = cycle the request was driven) where ready is seen, or -1.
    task automatic wait_ready(input bit wr, input int p, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((wr ? write_ready[p] : read_ready[p]) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_any_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((read_ready | write_ready) !== 4'b0) break;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset       = 1'b1;
        read_valid  = '0;
        write_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [7:0] a, input logic [7:0] d);
        int n;
        @(posedge clk); #1;
        write_valid[p]          = 1'b1;
        write_address[p*8 +: 8] = a;
        write_data[p*8 +: 8]    = d;
        wait_ready(1'b1, p, n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL write_latency p%0d: got %0d cycles, expected 3", p, n);
        end
        @(posedge clk); #1;
        write_valid[p] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int p, input logic [7:0] a, output logic [7:0] d);
        int n;
        @(posedge clk); #1;
        read_valid[p]          = 1'b1;
        read_address[p*8 +: 8] = a;
        wait_ready(1'b0, p, n);
        d = read_data[p*8 +: 8];
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL read_latency p%0d: got %0d cycles, expected 3", p, n);
        end
        @(posedge clk); #1;
        read_valid[p] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        read_valid    = '0;
        write_valid   = '0;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (read_ready !== 4'b0) begin
            errors++; $display("FAIL reset_read_ready: got %b, expected 0000", read_ready);
        end
        checks++;
        if (write_ready !== 4'b0) begin
            errors++; $display("FAIL reset_write_ready: got %b, expected 0000", write_ready);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL reset_read_data: got %h, expected 0", read_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_write_read();
        logic       early;
        logic [7:0] d;
        early = 1'b0;
        @(posedge clk); #1;
        write_valid[1]     = 1'b1;
        write_address[15:8] = 8'h10;
        write_data[15:8]    = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (write_ready !== 4'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL wr_early_ready: got %b, expected 0", early);
        end
        @(negedge clk);
        checks++;
        if (write_ready !== 4'b0010) begin
            errors++; $display("FAIL wr_ready_cycle3: got %b, expected 0010", write_ready);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL wr_busy: got %b, expected 1", busy);
        end
        @(posedge clk); #1;
        write_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ready !== 4'b0010) begin
            errors++; $display("FAIL wr_ready_cycle4: got %b, expected 0010", write_ready);
        end
        @(negedge clk);
        checks++;
        if (write_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_cycle5: got ready %b busy %b, expected 0000/0",
                     write_ready, busy);
        end
        do_read(2, 8'h10, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++; $display("FAIL wr_rd_data: got %h, expected a5", d);
        end
    endtask

    task automatic test_all_reads();
        logic [7:0] exp_d;
        for (int k = 0; k < 4; k++) do_write(k, 8'(k), 8'h50 + 8'(k));
        apply_reset();
        @(posedge clk); #1;
        read_valid   = 4'b1111;
        read_address = 32'h03020100;
        for (int k = 0; k < 4; k++) begin
            exp_d = 8'h50 + 8'(k);
            wait_any_ready();
            checks++;
            if (read_ready !== (4'b0001 << k) || write_ready !== 4'b0) begin
                errors++;
                $display("FAIL rr_order step%0d: got rd %b wr %b, expected rd %b wr 0000",
                         k, read_ready, write_ready, 4'b0001 << k);
            end
            checks++;
            if (read_data[k*8 +: 8] !== exp_d) begin
                errors++;
                $display("FAIL rr_data p%0d: got %h, expected %h", k, read_data[k*8 +: 8], exp_d);
            end
            @(posedge clk); #1;
            read_valid[k] = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (read_data !== 32'h53525150) begin
            errors++; $display("FAIL rr_all_data: got %h, expected 53525150", read_data);
        end
    endtask

    task automatic test_hold_valid();
        int n;
        @(posedge clk); #1;
        read_valid[1]      = 1'b1;
        read_address[15:8] = 8'h01;
        wait_ready(1'b0, 1, n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL hold_latency: got %0d, expected 3", n);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (read_ready !== 4'b0010 || read_data[15:8] !== 8'h51) begin
                errors++;
                $display("FAIL hold_cycle%0d: got rdy %b data %h, expected 0010/51",
                         j, read_ready, read_data[15:8]);
            end
        end
        @(posedge clk); #1;
        read_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (read_ready !== 4'b0010) begin
            errors++; $display("FAIL hold_drop_cycle: got %b, expected 0010", read_ready);
        end
        @(negedge clk);
        checks++;
        if (read_ready !== 4'b0000 || read_data[15:8] !== 8'h51) begin
            errors++;
            $display("FAIL hold_release: got rdy %b data %h, expected 0000/51",
                     read_ready, read_data[15:8]);
        end
    endtask

    task automatic test_same_cycle_rw();
        int         n;
        logic [7:0] d;
        do_write(0, 8'h20, 8'h11);
        apply_reset();
        @(posedge clk); #1;
        read_valid[0]      = 1'b1;
        read_address[7:0]  = 8'h20;
        write_valid[0]     = 1'b1;
        write_address[7:0] = 8'h20;
        write_data[7:0]    = 8'h22;
        wait_ready(1'b0, 0, n);
        checks++;
        if (n !== 3 || write_ready !== 4'b0) begin
            errors++;
            $display("FAIL same_rw_read_first: got lat %0d wr %b, expected 3/0000", n, write_ready);
        end
        checks++;
        if (read_data[7:0] !== 8'h11) begin
            errors++; $display("FAIL same_rw_old_data: got %h, expected 11", read_data[7:0]);
        end
        @(posedge clk); #1;
        read_valid[0] = 1'b0;
        wait_ready(1'b1, 0, n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL same_rw_write_served: got timeout, expected write_ready");
        end
        @(posedge clk); #1;
        write_valid[0] = 1'b0;
        @(posedge clk); #1;
        do_read(0, 8'h20, d);
        checks++;
        if (d !== 8'h22) begin
            errors++; $display("FAIL same_rw_new_data: got %h, expected 22", d);
        end
    endtask

    task automatic test_reset_access();
        logic [7:0] d;
        do_write(0, 8'h40, 8'h44);
        @(posedge clk); #1;
        write_valid[0]     = 1'b1;
        write_address[7:0] = 8'h40;
        write_data[7:0]    = 8'h33;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_acc_busy: got %b, expected 1", busy);
        end
        // Reset lands on the edge that would commit the write.
        @(posedge clk); #1;
        reset          = 1'b1;
        write_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (read_ready !== 4'b0 || write_ready !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_acc_state: got rd %b wr %b busy %b, expected 0000/0000/0",
                     read_ready, write_ready, busy);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL rst_acc_rdata: got %h, expected 0", read_data);
        end
        do_read(0, 8'h40, d);
        checks++;
        if (d !== 8'h44) begin
            errors++; $display("FAIL rst_acc_no_commit: got %h, expected 44", d);
        end
    endtask

    task automatic test_reset_respond();
        int         n;
        logic [7:0] d;
        @(posedge clk); #1;
        write_valid[1]      = 1'b1;
        write_address[15:8] = 8'h41;
        write_data[15:8]    = 8'h55;
        wait_ready(1'b1, 1, n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL rst_rsp_latency: got %0d, expected 3", n);
        end
        @(posedge clk); #1;
        reset          = 1'b1;
        write_valid[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (write_ready !== 4'b0) begin
            errors++; $display("FAIL rst_rsp_ready: got %b, expected 0000", write_ready);
        end
        do_read(1, 8'h41, d);
        checks++;
        if (d !== 8'h55) begin
            errors++; $display("FAIL rst_rsp_commit: got %h, expected 55", d);
        end
    endtask

    task automatic test_valid_drop_access();
        int         pulses;
        int         first;
        logic [7:0] d;
        pulses = 0;
        first  = -1;
        @(posedge clk); #1;
        write_valid[2]       = 1'b1;
        write_address[23:16] = 8'h70;
        write_data[23:16]    = 8'h99;
        @(posedge clk); #1;
        write_valid[2] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (write_ready[2] === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (pulses !== 1 || first !== 3) begin
            errors++;
            $display("FAIL drop_pulse: got %0d cycles from cycle %0d, expected 1 from 3",
                     pulses, first);
        end
        do_read(3, 8'h70, d);
        checks++;
        if (d !== 8'h99) begin
            errors++; $display("FAIL drop_commit: got %h, expected 99", d);
        end
    endtask

    task automatic test_rr_wrap();
        int         n;
        logic [7:0] d;
        apply_reset();
        do_write(3, 8'h60, 8'h77);
        @(posedge clk); #1;
        read_valid[0]      = 1'b1;
        read_address[7:0]  = 8'h60;
        write_valid[0]     = 1'b1;
        write_address[7:0] = 8'h60;
        write_data[7:0]    = 8'h88;
        wait_any_ready();
        checks++;
        if (read_ready !== 4'b0001 || write_ready !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_order: got rd %b wr %b, expected 0001/0000", read_ready, write_ready);
        end
        checks++;
        if (read_data[7:0] !== 8'h77) begin
            errors++; $display("FAIL wrap_data: got %h, expected 77", read_data[7:0]);
        end
        @(posedge clk); #1;
        read_valid[0] = 1'b0;
        wait_ready(1'b1, 0, n);
        @(posedge clk); #1;
        write_valid[0] = 1'b0;
        @(posedge clk); #1;
        do_read(0, 8'h60, d);
        checks++;
        if (d !== 8'h88) begin
            errors++; $display("FAIL wrap_write_commit: got %h, expected 88", d);
        end
        // Grant write port1 (index 5) so the search starts at write port2 (index 6).
        apply_reset();
        do_write(1, 8'h62, 8'h01);
        @(posedge clk); #1;
        read_valid[0]        = 1'b1;
        read_address[7:0]    = 8'h61;
        write_valid[2]       = 1'b1;
        write_address[23:16] = 8'h61;
        write_data[23:16]    = 8'h66;
        wait_any_ready();
        checks++;
        if (write_ready !== 4'b0100 || read_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rr_from_ptr: got rd %b wr %b, expected 0000/0100", read_ready, write_ready);
        end
        @(posedge clk); #1;
        write_valid[2] = 1'b0;
        wait_ready(1'b0, 0, n);
        checks++;
        if (n < 0 || read_data[7:0] !== 8'h66) begin
            errors++;
            $display("FAIL rr_from_ptr_data: got lat %0d data %h, expected served/66",
                     n, read_data[7:0]);
        end
        @(posedge clk); #1;
        read_valid[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_reads();
        test_hold_valid();
        test_same_cycle_rw();
        test_reset_access();
        test_reset_respond();
        test_valid_drop_access();
        test_rr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
